// File: rtl/mha_pe_pkg.sv
// Shared defaults, accumulator sizing and saturation limits for the MHA
// matrix-engine processing elements.
package mha_pe_pkg;

  localparam int unsigned DEF_BIT_WIDTH = 8;
  localparam int unsigned DEF_DEPTH     = 4;

  // Limits are produced at this fixed width and truncated by the caller.
  localparam int unsigned LIMIT_W = 64;

  // Partial-sum width: full product plus growth for DEPTH-1 additions.
  function automatic int unsigned acc_width(input int unsigned bw,
                                            input int unsigned depth);
    return 2 * bw + depth - 1;
  endfunction

  function automatic logic [LIMIT_W-1:0] smax(input int unsigned w);
    return (LIMIT_W'(1) << (w - 1)) - LIMIT_W'(1);
  endfunction

  // Bit pattern 100..0 once truncated to w bits.
  function automatic logic [LIMIT_W-1:0] smin(input int unsigned w);
    return LIMIT_W'(1) << (w - 1);
  endfunction

  function automatic logic [LIMIT_W-1:0] umax(input int unsigned w);
    if (w >= LIMIT_W) return '1;
    return (LIMIT_W'(1) << w) - LIMIT_W'(1);
  endfunction

  function automatic logic [LIMIT_W-1:0] umin(input int unsigned w);
    if (w == 0) return '0;
    return '0;
  endfunction

endpackage

// File: rtl/mac_pe_db_if.sv
// Per-PE link bundle: weight chain, data/valid/swap skew chain and
// partial-sum chain, plus the mode input and sticky overflow flag.
interface mac_pe_db_if
  import mha_pe_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int unsigned ACC_WIDTH = acc_width(DEF_BIT_WIDTH, DEF_DEPTH)
);
  logic                 is_signed;
  logic                 w_load;
  logic [BIT_WIDTH-1:0] w_in;
  logic [BIT_WIDTH-1:0] w_out;
  logic [BIT_WIDTH-1:0] data_in;
  logic                 data_valid_in;
  logic                 swap_in;
  logic [BIT_WIDTH-1:0] data_out;
  logic                 data_valid_out;
  logic                 swap_out;
  logic [ACC_WIDTH-1:0] acc_in;
  logic [ACC_WIDTH-1:0] acc_out;
  logic                 ovf;

  modport master (
    output is_signed, w_load, w_in, data_in, data_valid_in, swap_in, acc_in,
    input  w_out, data_out, data_valid_out, swap_out, acc_out, ovf
  );

  modport slave (
    input  is_signed, w_load, w_in, data_in, data_valid_in, swap_in, acc_in,
    output w_out, data_out, data_valid_out, swap_out, acc_out, ovf
  );
endinterface

// File: rtl/mac_pe_db_sat_adder.sv
// Extend-and-add of partial sum and product with overflow detection and
// optional clamp to the representable range of the accumulator.
module sat_adder
  import mha_pe_pkg::*;
#(
  parameter int unsigned P_WIDTH   = 2 * DEF_BIT_WIDTH,
  parameter int unsigned ACC_WIDTH = acc_width(DEF_BIT_WIDTH, DEF_DEPTH),
  parameter int unsigned SATURATE  = 1
) (
  input  logic                 is_signed,
  input  logic [ACC_WIDTH-1:0] a,
  input  logic [P_WIDTH-1:0]   b,
  output logic [ACC_WIDTH-1:0] sum,
  output logic                 ovf
);
  localparam logic [ACC_WIDTH-1:0] S_MAX = ACC_WIDTH'(smax(ACC_WIDTH));
  localparam logic [ACC_WIDTH-1:0] S_MIN = ACC_WIDTH'(smin(ACC_WIDTH));
  localparam logic [ACC_WIDTH-1:0] U_MAX = ACC_WIDTH'(umax(ACC_WIDTH));

  logic [ACC_WIDTH:0] a_x;
  logic [ACC_WIDTH:0] b_x;
  logic [ACC_WIDTH:0] s;

  // One guard bit above the accumulator exposes signed overflow / unsigned carry.
  always_comb begin
    a_x = {is_signed & a[ACC_WIDTH-1], a};
    b_x = {{(ACC_WIDTH + 1 - P_WIDTH){is_signed & b[P_WIDTH-1]}}, b};
    s   = a_x + b_x;
    ovf = is_signed ? (s[ACC_WIDTH] ^ s[ACC_WIDTH-1]) : s[ACC_WIDTH];
    sum = s[ACC_WIDTH-1:0];
    if ((SATURATE != 0) && ovf) begin
      if (is_signed) sum = s[ACC_WIDTH] ? S_MIN : S_MAX;
      else           sum = U_MAX;
    end
  end
endmodule

// File: rtl/mac_pe_db.sv
// Weight-stationary systolic PE with shadow/active weight double buffer,
// runtime signed mode, swap token travelling with the data skew and a
// sticky overflow flag cleared at each new tile.
module mac_pe_db
  import mha_pe_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned ACC_WIDTH = acc_width(BIT_WIDTH, DEPTH),
  parameter int unsigned SATURATE  = 1
) (
  input logic        clk,
  input logic        reset,
  mac_pe_db_if.slave pe
);
  logic [BIT_WIDTH-1:0]   shadow_w_q, shadow_w_d;
  logic [BIT_WIDTH-1:0]   active_w_q, active_w_d;
  logic [BIT_WIDTH-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   swap_q, swap_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                   ovf_q, ovf_d;

  logic [2*BIT_WIDTH-1:0] w_x, d_x, product;
  logic [ACC_WIDTH-1:0]   sum;
  logic                   add_ovf;

  // Product of the active weight and the registered datum; bubbles give 0.
  // Only the low 2*BIT_WIDTH bits are kept, so extending each operand to that
  // width is enough for an exact signed or unsigned product.
  always_comb begin
    w_x     = {{BIT_WIDTH{pe.is_signed & active_w_q[BIT_WIDTH-1]}}, active_w_q};
    d_x     = {{BIT_WIDTH{pe.is_signed & data_q[BIT_WIDTH-1]}}, data_q};
    product = valid_q ? (w_x * d_x) : '0;
  end

  sat_adder #(
    .P_WIDTH  (2 * BIT_WIDTH),
    .ACC_WIDTH(ACC_WIDTH),
    .SATURATE (SATURATE)
  ) u_sat_adder (
    .is_signed(pe.is_signed),
    .a        (pe.acc_in),
    .b        (product),
    .sum      (sum),
    .ovf      (add_ovf)
  );

  // Next state: shadow chain shift, swap into active, data skew stage, accumulate.
  always_comb begin
    shadow_w_d = shadow_w_q;
    if (pe.w_load) shadow_w_d = pe.w_in;
    active_w_d = active_w_q;
    if (pe.swap_in) active_w_d = shadow_w_q;
    data_d  = pe.data_in;
    valid_d = pe.data_valid_in;
    swap_d  = pe.swap_in;
    acc_d   = sum;
    // A new tile clears the flag, but an overflow on the same edge wins.
    ovf_d   = add_ovf | (ovf_q & ~pe.swap_in);
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_w_q <= '0;
      active_w_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      swap_q     <= 1'b0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      shadow_w_q <= shadow_w_d;
      active_w_q <= active_w_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      swap_q     <= swap_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
    end
  end

  assign pe.w_out          = shadow_w_q;
  assign pe.data_out       = data_q;
  assign pe.data_valid_out = valid_q;
  assign pe.swap_out       = swap_q;
  assign pe.acc_out        = acc_q;
  assign pe.ovf            = ovf_q;
endmodule

// File: tb/tb_mac_pe_db.sv
// Bench for mac_pe_db: a saturating and a wrapping instance share one
// stimulus stream and are compared against an arithmetic reference model.
module tb_mac_pe_db;
  localparam int BW = 8;
  localparam int AW = 2 * BW + 4 - 1;

  logic          clk;
  logic          reset;
  logic          is_signed, w_load, data_valid_in, swap_in;
  logic [BW-1:0] w_in, data_in;
  logic [AW-1:0] acc_in;

  int checks   = 0;
  int failures = 0;

  mac_pe_db_if #(.BIT_WIDTH(BW), .ACC_WIDTH(AW)) if_s ();
  mac_pe_db_if #(.BIT_WIDTH(BW), .ACC_WIDTH(AW)) if_w ();

  assign if_s.is_signed = is_signed;     assign if_w.is_signed = is_signed;
  assign if_s.w_load = w_load;           assign if_w.w_load = w_load;
  assign if_s.w_in = w_in;               assign if_w.w_in = w_in;
  assign if_s.data_in = data_in;         assign if_w.data_in = data_in;
  assign if_s.data_valid_in = data_valid_in;
  assign if_w.data_valid_in = data_valid_in;
  assign if_s.swap_in = swap_in;         assign if_w.swap_in = swap_in;
  assign if_s.acc_in = acc_in;           assign if_w.acc_in = acc_in;

  mac_pe_db #(.BIT_WIDTH(BW), .DEPTH(4), .ACC_WIDTH(AW), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .pe(if_s));
  mac_pe_db #(.BIT_WIDTH(BW), .DEPTH(4), .ACC_WIDTH(AW), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .pe(if_w));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  // Reference model state
  logic [BW-1:0] m_shadow, m_active, m_data;
  logic          m_valid, m_swap, m_ovf;
  logic [AW-1:0] m_acc_s, m_acc_w;

  function automatic longint opval(input logic [BW-1:0] x, input logic sg);
    if (sg) return longint'($signed(x));
    return longint'(x);
  endfunction

  function automatic longint accval(input logic [AW-1:0] x, input logic sg);
    if (sg) return longint'($signed(x));
    return longint'(x);
  endfunction

  task automatic model_step();
    longint p, s, lo, hi, t;
    logic   o;
    if (reset) begin
      m_shadow = '0; m_active = '0; m_data = '0; m_valid = 0; m_swap = 0;
      m_ovf = 0; m_acc_s = '0; m_acc_w = '0;
      return;
    end
    p = m_valid ? opval(m_active, is_signed) * opval(m_data, is_signed) : 0;
    s = accval(acc_in, is_signed) + p;
    if (is_signed) begin
      lo = -(longint'(1) << (AW - 1));
      hi = (longint'(1) << (AW - 1)) - 1;
    end else begin
      lo = 0;
      hi = (longint'(1) << AW) - 1;
    end
    o = (s < lo) || (s > hi);
    t = o ? ((s > hi) ? hi : lo) : s;
    m_acc_s = t[AW-1:0];
    m_acc_w = s[AW-1:0];
    m_ovf   = o | (m_ovf & ~swap_in);
    if (swap_in) m_active = m_shadow;
    if (w_load)  m_shadow = w_in;
    m_data  = data_in;
    m_valid = data_valid_in;
    m_swap  = swap_in;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("w_out",      32'(if_s.w_out),          32'(m_shadow));
    chk("data_out",   32'(if_s.data_out),       32'(m_data));
    chk("valid_out",  32'(if_s.data_valid_out), 32'(m_valid));
    chk("swap_out",   32'(if_s.swap_out),       32'(m_swap));
    chk("acc_sat",    32'(if_s.acc_out),        32'(m_acc_s));
    chk("acc_wrap",   32'(if_w.acc_out),        32'(m_acc_w));
    chk("ovf_sat",    32'(if_s.ovf),            32'(m_ovf));
    chk("ovf_wrap",   32'(if_w.ovf),            32'(m_ovf));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    w_load = 0; w_in = '0; data_in = '0; data_valid_in = 0; swap_in = 0; acc_in = '0;
  endtask

  initial begin
    reset = 1; is_signed = 0; idle();
    model_step();
    #1;
    check_all();
    chk("reset_acc", 32'(if_s.acc_out), 32'd0);
    tick(); tick();
    reset = 0;

    // Unsigned MAC: 5*7+10
    w_load = 1; w_in = 8'd5; tick();
    chk("w_out_5", 32'(if_s.w_out), 32'd5);
    w_load = 0; swap_in = 1; data_in = 8'd7; data_valid_in = 1; acc_in = '0; tick();
    swap_in = 0; data_valid_in = 0; data_in = '0; acc_in = AW'(10); tick();
    chk("mac_45", 32'(if_s.acc_out), 32'd45);
    tick();
    chk("bubble_10", 32'(if_s.acc_out), 32'd10);

    // Double buffer: active 3, shadow 4 loaded meanwhile, swap with 3rd datum
    acc_in = '0;
    w_load = 1; w_in = 8'd3; tick();
    w_load = 0; swap_in = 1; data_in = 8'd2; data_valid_in = 1; tick();
    swap_in = 0; w_load = 1; w_in = 8'd4; tick();
    chk("db_r1", 32'(if_s.acc_out), 32'd6);
    w_load = 0; swap_in = 1; tick();
    chk("db_r2", 32'(if_s.acc_out), 32'd6);
    data_valid_in = 0; w_load = 1; w_in = 8'd9; swap_in = 1; tick();
    chk("db_r3", 32'(if_s.acc_out), 32'd8);
    chk("db_shadow9", 32'(if_s.w_out), 32'd9);
    w_load = 0; swap_in = 0; data_in = 8'd1; data_valid_in = 1; tick();
    data_valid_in = 0; tick();
    chk("db_active4", 32'(if_s.acc_out), 32'd4);

    // Signed: -1 * -128 + -1 = 127
    is_signed = 1; w_load = 1; w_in = 8'hFF; tick();
    w_load = 0; swap_in = 1; data_in = 8'h80; data_valid_in = 1; tick();
    swap_in = 0; data_valid_in = 0; acc_in = '1; tick();
    chk("signed_127", 32'(if_s.acc_out), 32'd127);
    chk("signed_ovf0", 32'(if_s.ovf), 32'd0);
    // Unsigned, same operands: 32640 + (2^AW-1) overflows
    is_signed = 0; acc_in = '0; data_valid_in = 1; tick();
    data_valid_in = 0; acc_in = '1; tick();
    chk("uns_sat", 32'(if_s.acc_out), 32'h7FFFF);
    chk("uns_wrap", 32'(if_w.acc_out), 32'd32639);
    chk("uns_ovf", 32'(if_w.ovf), 32'd1);

    // Signed saturation near max positive
    is_signed = 1; acc_in = '0; w_load = 1; w_in = 8'd127; tick();
    w_load = 0; swap_in = 1; data_in = 8'd127; data_valid_in = 1; tick();
    chk("swap_clears", 32'(if_s.ovf), 32'd0);
    swap_in = 0; data_valid_in = 0; acc_in = AW'(262134); tick();
    chk("sat_max", 32'(if_s.acc_out), 32'h3FFFF);
    chk("sat_wrap", 32'(if_w.acc_out), 32'h43EF7);
    chk("sat_ovf", 32'(if_s.ovf), 32'd1);
    acc_in = '0; tick(); tick();
    chk("ovf_sticky", 32'(if_s.ovf), 32'd1);
    swap_in = 1; tick();
    chk("ovf_cleared", 32'(if_s.ovf), 32'd0);
    swap_in = 0;

    // Reset in the middle of a valid stream
    data_valid_in = 1; data_in = 8'd3; acc_in = AW'(100); tick(); tick();
    #2 reset = 1;
    #1;
    model_step();
    check_all();
    chk("rst_acc", 32'(if_s.acc_out), 32'd0);
    chk("rst_valid", 32'(if_s.data_valid_out), 32'd0);
    tick();
    reset = 0;
    data_valid_in = 1; data_in = 8'd9; acc_in = AW'(55); tick();
    data_valid_in = 0; tick();
    chk("post_rst", 32'(if_s.acc_out), 32'd55);

    // Randomized traffic with acc_in biased toward the range limits
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) begin
        data_valid_in = 0; swap_in = 0; w_load = 0; tick();
        is_signed = 1'($urandom_range(0, 1));
      end
      w_load        = 1'($urandom_range(0, 1));
      w_in          = BW'($urandom());
      data_in       = BW'($urandom());
      data_valid_in = ($urandom_range(0, 3) != 0);
      swap_in       = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0:       acc_in = AW'(262143 - $urandom_range(0, 20000));
        1:       acc_in = AW'(262144 + $urandom_range(0, 20000));
        2:       acc_in = AW'(524287 - $urandom_range(0, 20000));
        default: acc_in = AW'($urandom());
      endcase
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
